// File: rtl/code_entry.sv
// code_entry: keypad digit collector and code comparator with failure lockout and reprogramming
module code_entry #(
  parameter int DIGITS = 4,
  parameter logic [DIGITS*4-1:0] DEFAULT_CODE = 16'h1234,
  parameter int MAX_FAIL = 3,
  parameter int LOCKOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  accept_en,
  input  logic                  key_valid,
  input  logic [3:0]            key_digit,
  input  logic                  key_enter,
  input  logic                  key_clear,
  input  logic                  prog_en,
  input  logic [DIGITS*4-1:0]   prog_code,
  output logic [2:0]            digit_count,
  output logic                  code_match,
  output logic                  code_mismatch,
  output logic                  busy,
  output logic                  locked_out,
  output logic [2:0]            fail_count
);
  localparam int LW = $clog2(LOCKOUT_CYC + 1);
  localparam logic [2:0] FULL = 3'(DIGITS);
  localparam logic [2:0] MAXF = 3'(MAX_FAIL);
  typedef enum logic [2:0] {IDLE, COLLECT, COMPARE, RESULT, LOCKOUT} state_t;
  state_t state;
  logic [DIGITS*4-1:0] entry, code;
  logic [LW-1:0] lock_cnt;
  logic dig_ok, hit;
  always_comb begin
    dig_ok = key_valid && key_digit <= 4'd9 && digit_count < FULL;
    hit = digit_count == FULL && entry == code;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      entry <= '0;
      code <= DEFAULT_CODE;
      lock_cnt <= '0;
      digit_count <= '0;
      code_match <= 1'b0;
      code_mismatch <= 1'b0;
      busy <= 1'b0;
      locked_out <= 1'b0;
      fail_count <= '0;
    end else begin
      code_match <= 1'b0;
      code_mismatch <= 1'b0;
      case (state)
        IDLE, COLLECT: begin
          if (!accept_en) begin
            state <= IDLE;
            entry <= '0;
            digit_count <= '0;
            if (state == IDLE && prog_en) code <= prog_code;
          end else begin
            state <= COLLECT;
            if (key_clear) begin
              entry <= '0;
              digit_count <= '0;
            end else if (key_enter) begin
              state <= COMPARE;
              busy <= 1'b1;
            end else if (dig_ok) begin
              entry <= {entry[DIGITS*4-5:0], key_digit};
              digit_count <= digit_count + 3'd1;
            end
          end
        end
        COMPARE: begin
          state <= RESULT;
          code_match <= hit;
          code_mismatch <= !hit;
          fail_count <= hit ? 3'd0 : (fail_count >= MAXF ? MAXF : fail_count + 3'd1);
        end
        RESULT: begin
          busy <= 1'b0;
          entry <= '0;
          digit_count <= '0;
          // the increment just made in COMPARE decides whether we lock out
          if (code_mismatch && fail_count == MAXF) begin
            state <= LOCKOUT;
            locked_out <= 1'b1;
            lock_cnt <= LW'(LOCKOUT_CYC - 1);
          end else begin
            state <= COLLECT;
          end
        end
        LOCKOUT: begin
          if (lock_cnt == '0) begin
            state <= IDLE;
            locked_out <= 1'b0;
            fail_count <= '0;
          end else begin
            lock_cnt <= lock_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
